// File: rtl/control_unit_pkg.sv
// Shared constants for the accumulator-processor controller: opcodes, state
// encodings, A-source selects and the strobe bundle driven each cycle.
package cu_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [3:0] ST_START  = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_LOAD   = 4'd3;
  localparam logic [3:0] ST_STORE  = 4'd4;
  localparam logic [3:0] ST_ADD    = 4'd5;
  localparam logic [3:0] ST_SUB    = 4'd6;
  localparam logic [3:0] ST_INPUT  = 4'd7;
  localparam logic [3:0] ST_JZ     = 4'd8;
  localparam logic [3:0] ST_JPOS   = 4'd9;
  localparam logic [3:0] ST_HALT   = 4'd10;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_MEM = 2'b01;
  localparam logic [1:0] ASEL_IN  = 2'b10;

  typedef struct packed {
    logic       irload;
    logic       jmpmux;
    logic       pcload;
    logic       meminst;
    logic       memwr;
    logic [1:0] asel;
    logic       aload;
    logic       sub;
    logic       halt;
  } ctrl_t;

  function automatic logic [3:0] exec_state(input logic [2:0] op);
    case (op)
      OP_LOAD:  return ST_LOAD;
      OP_STORE: return ST_STORE;
      OP_ADD:   return ST_ADD;
      OP_SUB:   return ST_SUB;
      OP_IN:    return ST_INPUT;
      OP_JZ:    return ST_JZ;
      OP_JPOS:  return ST_JPOS;
      default:  return ST_HALT;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Controller <-> datapath bundle: opcode, flags and operator key in; strobes out.
interface control_unit_if;
  logic [2:0] IR;
  logic       Aeq0;
  logic       Apos;
  logic       Enter;
  logic       IRload;
  logic       JMPmux;
  logic       PCload;
  logic       Meminst;
  logic       MemWr;
  logic [1:0] Asel;
  logic       Aload;
  logic       Sub;
  logic       Halt;
  logic [3:0] State;

  modport master (
    input  IR, Aeq0, Apos, Enter,
    output IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, Halt, State
  );

  modport slave (
    output IR, Aeq0, Apos, Enter,
    input  IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, Halt, State
  );
endinterface

// File: rtl/control_unit_enter_edge.sv
// Rising-edge detector for the operator Enter key.
module enter_edge (
  input  logic Clock,
  input  logic Reset,
  input  logic Enter,
  output logic Press
);

  logic enter_q;

  // Resetting high means a key held through reset never registers as a press.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) enter_q <= 1'b1;
    else       enter_q <= Enter;
  end

  assign Press = Enter & ~enter_q;

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute FSM driving every datapath strobe of the 8-bit
// accumulator processor.
module control_unit
  import cu_pkg::*;
(
  input  logic          Clock,
  input  logic          Reset,
  control_unit_if.master cu
);

  logic [3:0] state_q, state_d;
  logic       press;
  ctrl_t      ctrl;

  enter_edge u_enter_edge (
    .Clock (Clock),
    .Reset (Reset),
    .Enter (cu.Enter),
    .Press (press)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= ST_START;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      ST_START: state_d = ST_FETCH;
      ST_FETCH: begin
        ctrl.irload = 1'b1;
        ctrl.pcload = 1'b1;
        state_d     = ST_DECODE;
      end
      ST_DECODE: begin
        ctrl.meminst = 1'b1;
        state_d      = exec_state(cu.IR);
      end
      ST_LOAD: begin
        ctrl.meminst = 1'b1;
        ctrl.asel    = ASEL_MEM;
        ctrl.aload   = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_STORE: begin
        ctrl.meminst = 1'b1;
        ctrl.memwr   = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_ADD, ST_SUB: begin
        ctrl.meminst = 1'b1;
        ctrl.asel    = ASEL_ALU;
        ctrl.aload   = 1'b1;
        ctrl.sub     = (state_q == ST_SUB);
        state_d      = ST_FETCH;
      end
      ST_INPUT: begin
        ctrl.asel  = ASEL_IN;
        ctrl.aload = press;
        if (press) state_d = ST_FETCH;
      end
      // A false flag falls through: PC+1 was already loaded in FETCH.
      ST_JZ: begin
        ctrl.pcload = cu.Aeq0;
        ctrl.jmpmux = cu.Aeq0;
        state_d     = ST_FETCH;
      end
      ST_JPOS: begin
        ctrl.pcload = cu.Apos;
        ctrl.jmpmux = cu.Apos;
        state_d     = ST_FETCH;
      end
      ST_HALT:  ctrl.halt = 1'b1;
      default:  state_d = ST_START;
    endcase
  end

  assign cu.IRload  = ctrl.irload;
  assign cu.JMPmux  = ctrl.jmpmux;
  assign cu.PCload  = ctrl.pcload;
  assign cu.Meminst = ctrl.meminst;
  assign cu.MemWr   = ctrl.memwr;
  assign cu.Asel    = ctrl.asel;
  assign cu.Aload   = ctrl.aload;
  assign cu.Sub     = ctrl.sub;
  assign cu.Halt    = ctrl.halt;
  assign cu.State   = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: instruction-level model checked every cycle plus
// directed literal checks on each opcode, the Enter handshake and reset.
module tb_control_unit;
  import cu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  control_unit_if dp();

  control_unit dut (
    .Clock (clk),
    .Reset (rst),
    .cu    (dp)
  );

  int n_pass = 0;
  int n_chk  = 0;
  int aload_cnt = 0;

  logic [13:0] act;
  assign act = {dp.IRload, dp.JMPmux, dp.PCload, dp.Meminst, dp.MemWr,
                dp.Asel, dp.Aload, dp.Sub, dp.Halt, dp.State};

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
  endtask

  // Instruction-level model: phase 0=start, 1=fetch, 2=decode, 3=execute.
  int         m_phase;
  logic [2:0] m_op;
  logic       m_enter;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_op    <= 3'b000;
      m_enter <= 1'b1;
    end else begin
      m_enter <= dp.Enter;
      case (m_phase)
        0: m_phase <= 1;
        1: m_phase <= 2;
        2: begin m_phase <= 3; m_op <= dp.IR; end
        default: begin
          if (m_op == 3'b111) m_phase <= 3;
          else if (m_op == 3'b100 && !(dp.Enter && !m_enter)) m_phase <= 3;
          else m_phase <= 1;
        end
      endcase
    end
  end

  function automatic logic [13:0] model_out(input int ph, input logic [2:0] op,
                                            input logic eq, input logic pos,
                                            input logic prs);
    logic irl, jm, pcl, mi, mw, al, sb, hl;
    logic [1:0] as;
    logic [3:0] st;
    {irl, jm, pcl, mi, mw, al, sb, hl} = 8'b0;
    as = 2'b00;
    st = ST_START;
    if (ph == 1) begin irl = 1; pcl = 1; st = ST_FETCH; end
    else if (ph == 2) begin mi = 1; st = ST_DECODE; end
    else if (ph == 3) begin
      case (op)
        3'b000: begin mi = 1; as = 2'b01; al = 1; st = ST_LOAD; end
        3'b001: begin mi = 1; mw = 1; st = ST_STORE; end
        3'b010: begin mi = 1; al = 1; st = ST_ADD; end
        3'b011: begin mi = 1; al = 1; sb = 1; st = ST_SUB; end
        3'b100: begin as = 2'b10; al = prs; st = ST_INPUT; end
        3'b101: begin pcl = eq; jm = eq; st = ST_JZ; end
        3'b110: begin pcl = pos; jm = pos; st = ST_JPOS; end
        default: begin hl = 1; st = ST_HALT; end
      endcase
    end
    return {irl, jm, pcl, mi, mw, as, al, sb, hl, st};
  endfunction

  always @(negedge clk) begin
    check("cycle", {18'b0, act},
          {18'b0, model_out(m_phase, m_op, dp.Aeq0, dp.Apos, dp.Enter & ~m_enter)});
    if (dp.Aload) aload_cnt <= aload_cnt + 1;
  end

  task automatic wait_state(input logic [3:0] s, input string nm);
    bit hit = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dp.State === s) begin hit = 1; break; end
    end
    if (!hit) begin
      n_chk++;
      $display("FAIL %s: timeout, state %h expected %h", nm, dp.State, s);
    end
    #1;
  endtask

  int al0, hc;

  initial begin
    rst = 1'b1; dp.IR = 3'b100; dp.Enter = 1'b0; dp.Aeq0 = 1'b0; dp.Apos = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", {18'b0, act}, {28'b0, ST_START});
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("fetch", {dp.IRload, dp.PCload, dp.State}, {2'b11, ST_FETCH});

    // IN: wait, one press, then a long hold consumes only that one
    wait_state(ST_INPUT, "to_input");
    al0 = aload_cnt;
    repeat (5) @(negedge clk); #1;
    check("in_wait", aload_cnt - al0, 0);
    @(posedge clk); #1 dp.Enter = 1'b1; al0 = aload_cnt;
    repeat (21) @(negedge clk); #1;
    check("in_once", aload_cnt - al0, 1);

    @(posedge clk); #1 dp.Enter = 1'b0; dp.IR = 3'b011;
    @(posedge clk); #1 dp.Enter = 1'b1;
    wait_state(ST_SUB, "to_sub");
    check("sub", {dp.Meminst, dp.Asel, dp.Sub, dp.Aload}, 5'b10011);
    dp.IR = 3'b010; dp.Enter = 1'b0;
    @(negedge clk);
    check("sub_next", dp.State, ST_FETCH);
    wait_state(ST_ADD, "to_add");
    check("add", {dp.Meminst, dp.Asel, dp.Sub, dp.Aload}, 5'b10001);

    dp.IR = 3'b101; dp.Aeq0 = 1'b1;
    wait_state(ST_JZ, "to_jz1");
    check("jz_taken", {dp.PCload, dp.JMPmux}, 2'b11);
    dp.Aeq0 = 1'b0; dp.Apos = 1'b1;
    wait_state(ST_JZ, "to_jz0");
    check("jz_fall", {dp.PCload, dp.JMPmux}, 2'b00);
    dp.IR = 3'b110;
    wait_state(ST_JPOS, "to_jpos1");
    check("jpos_taken", {dp.PCload, dp.JMPmux}, 2'b11);
    dp.Apos = 1'b0; dp.Aeq0 = 1'b1;
    wait_state(ST_JPOS, "to_jpos0");
    check("jpos_fall", {dp.PCload, dp.JMPmux}, 2'b00);
    dp.IR = 3'b101; dp.Apos = 1'b1;
    wait_state(ST_JZ, "to_jzf");
    check("jz_fault", {dp.PCload, dp.JMPmux}, 2'b11);

    dp.IR = 3'b001; dp.Enter = 1'b1;
    wait_state(ST_STORE, "to_store");
    check("store", {dp.Meminst, dp.MemWr, dp.Aload, dp.Asel}, 5'b11000);
    dp.IR = 3'b000; dp.Enter = 1'b0;
    wait_state(ST_LOAD, "to_load");
    check("load", {dp.Asel, dp.Aload}, 3'b011);

    dp.IR = 3'b111; dp.Enter = 1'b1;
    wait_state(ST_HALT, "to_halt");
    hc = 0;
    repeat (50) begin
      @(negedge clk);
      if (act[13:4] === 10'b0000000001) hc++;
    end
    check("halt50", hc, 50);
    #1 rst = 1'b1;
    #1 check("halt_rst", {dp.Halt, dp.State}, {1'b0, ST_START});
    @(posedge clk); #1 rst = 1'b0; dp.IR = 3'b000;

    // Asynchronous reset mid-DECODE, Enter held high throughout
    wait_state(ST_DECODE, "to_decode");
    #1 rst = 1'b1;
    #1 check("async_rst", {18'b0, act}, {28'b0, ST_START});
    #1 rst = 1'b0; dp.IR = 3'b100;
    @(negedge clk);
    check("restart", dp.State, ST_FETCH);
    wait_state(ST_INPUT, "to_input2");
    al0 = aload_cnt;
    repeat (8) @(negedge clk); #1;
    check("in_held", aload_cnt - al0, 0);
    @(posedge clk); #1 dp.Enter = 1'b0;
    @(posedge clk); #1 dp.Enter = 1'b1;
    repeat (3) @(negedge clk); #1;
    check("in_press", aload_cnt - al0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

FSM controller for the 8-bit accumulator processor. It sits opposite the datapath (`DP`): it consumes the opcode and status flags the datapath reports and drives every datapath control strobe. Each instruction runs through fetch, decode and execute. `IN` waits for an operator Enter pulse, and `HALT` parks the machine until reset.

## Interface
Parameters:
- None. The instruction set is fixed.

Ports:
- `Clock`  in  1  sole clock; all state changes on the rising edge
- `Reset`  in  1  asynchronous, active-high; forces state `START`
- `IR`  in  3  opcode bits IR[7:5] from the datapath instruction register
- `Aeq0`  in  1  accumulator == 0
- `Apos`  in  1  accumulator > 0 (signed, bit 7 clear and not zero)
- `Enter`  in  1  operator key, level; may be held for many cycles
- `IRload`  out  1  load the instruction register from RAM[PC]
- `JMPmux`  out  1  PC source: 1 = IR[4:0], 0 = PC+1
- `PCload`  out  1  load the PC
- `Meminst`  out  1  RAM address: 1 = IR[4:0], 0 = PC
- `MemWr`  out  1  write A into RAM[IR[4:0]]
- `Asel`  out  2  A source: 00 = ALU, 01 = RAM data, 10 = INPUT, 11 = unused
- `Aload`  out  1  load A
- `Sub`  out  1  ALU op: 1 = A − M, 0 = A + M
- `Halt`  out  1  high while in `HALT`
- `State`  out  4  current state encoding, for debug/LEDs

## Operation
Opcodes:
- 000 `LOAD` A←M[a]
- 001 `STORE` M[a]←A
- 010 `ADD` A←A+M[a]
- 011 `SUB` A←A−M[a]
- 100 `IN` A←INPUT
- 101 `JZ` if A==0, PC←a
- 110 `JPOS` if A>0, PC←a
- 111 `HALT`

States and transitions:
- `START` → `FETCH`. All outputs are 0.
- `FETCH`: IRload=1, PCload=1, JMPmux=0, Meminst=0. Next state is `DECODE`.
- `DECODE`: Meminst=1, so the operand address is presented for the combinational RAM read. Next state is the execute state selected by `IR`.
- `LOAD`: Meminst=1, Asel=01, Aload=1. Next state is `FETCH`.
- `STORE`: Meminst=1, MemWr=1. Next state is `FETCH`.
- `ADD` / `SUB`: Meminst=1, Asel=00, Aload=1, Sub=0 for `ADD` / 1 for `SUB`. Next state is `FETCH`.
- `INPUT`: Asel=10 throughout. Aload=1 only in the cycle where the Enter rising edge is detected, and the state then moves to `FETCH`; otherwise it stays in `INPUT`.
- `JZ`: PCload=JMPmux=Aeq0. Next state is `FETCH`.
- `JPOS`: PCload=JMPmux=Apos. Next state is `FETCH`.
- `HALT`: Halt=1, all strobes 0. It self-loops until `Reset`.

Output and arithmetic rules:
- Strobes decode combinationally from the state register plus Aeq0/Apos/Enter edge. Any strobe not listed for a state is 0.
- Enter edge detection uses internal register `enter_q`: edge = Enter & ~enter_q. `enter_q` resets to 1, so a key held through reset does not count as a press.
- Sub is never asserted outside `SUB`. Overflow is the datapath's concern and wraps mod 256.

## Timing
Reset:
- Asynchronous. On assertion, state = `START` and enter_q = 1.
- Output reset values: every strobe 0, Asel=00, Halt=0, State = `START` encoding.
- Reset asserted mid-instruction aborts it with no partial strobe. Datapath registers are cleared by the same `Reset`.

Latency per instruction, FETCH through execute:
- `LOAD`, `STORE`, `ADD`, `SUB`, `JZ`, `JPOS`: 3 cycles.
- `IN`: 3 cycles plus the wait for an Enter edge.
- The first FETCH occurs in the cycle after `START`.

Enter handshake:
- If Enter is already high on entry to `INPUT`, it must drop and rise again.
- Enter held high consumes exactly one `IN`.
- Enter toggling outside `INPUT` is ignored, but `enter_q` still tracks it.

Simultaneous events:
- A jump whose flag is false falls through to PC+1, which was already applied in `FETCH`.
- Aeq0 and Apos are both 1 only on datapath fault. The jump still follows only the flag of its own opcode.

## Structure
- Package `cu_pkg` holds:
  - the opcode constants (`OP_LOAD` … `OP_HALT`, 3 bits);
  - the state encodings (4 bits: START, FETCH, DECODE, LOAD, STORE, ADD, SUB, INPUT, JZ, JPOS, HALT);
  - the Asel constants (`ASEL_ALU`, `ASEL_MEM`, `ASEL_IN`).
- One sub-module `enter_edge` (Clock, Reset, Enter → Press) owns `enter_q`.
- Everything else is the state register plus combinational next-state and output decode.

## Test plan
- Reset, then release, with IR=100 and Enter=0: `START`, `FETCH` (IRload=PCload=1), `DECODE`, `INPUT`, holding with Aload=0. Raise Enter: exactly one Aload=1 cycle with Asel=10. Hold Enter 20 cycles: no further Aload.
- IR=011 sequence: in the execute cycle Meminst=1, Asel=00, Sub=1, Aload=1; then `FETCH`. IR=010 gives identical timing with Sub=0.
- IR=101 with Aeq0=1: execute cycle has PCload=JMPmux=1. Repeat with Aeq0=0: PCload=0. Same pair for IR=110/Apos.
- IR=001: only MemWr=1 and Meminst=1 in the execute cycle, Aload=0. IR=000: Asel=01, Aload=1.
- IR=111: Halt=1 and all strobes 0 for 50 cycles. Reset asserted: immediate `START`, Halt=0.
- Reset pulse asserted mid-`DECODE` between clock edges: outputs go to 0 asynchronously, and the next `FETCH` follows `START`.
